regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port general-purpose register file for the MIPS core, the successor to the single-write, two-read register file. It provides a configurable number of combinational read ports and clocked write ports, with same-cycle write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard so decode can detect pending writebacks (load-use, multi-cycle ops) without external tracking. It sits between decode (reads, busy set) and writeback (writes, busy clear).

## Interface
- DATA_WIDTH, 32, width of each register
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- READ_PORTS, 2, number of read ports (1..4)
- WRITE_PORTS, 2, number of write ports (1..2)
- ZERO_REG, 1, 1: register 0 reads 0, writes to it dropped, never busy
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  WRITE_PORTS  per-port write enable
- wr_addr  in  WRITE_PORTS*ADDR_WIDTH  packed write indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wr_data  in  WRITE_PORTS*DATA_WIDTH  packed write data
- wr_clear  in  WRITE_PORTS  per-port: this write also clears the register's busy bit
- rd_addr  in  READ_PORTS*ADDR_WIDTH  packed read indices
- rd_data  out  READ_PORTS*DATA_WIDTH  packed read data (combinational)
- rd_busy  out  READ_PORTS  busy status of the addressed register (combinational)
- set_en  in  1  mark a register busy (issue of a pending-writeback instruction)
- set_addr  in  ADDR_WIDTH  register to mark busy

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH array plus one busy bit per register.
- Write: on edge, for each port with wr_en=1, reg[wr_addr]<=wr_data. Two ports same address same cycle: highest-numbered port wins (data and clear). ZERO_REG=1 and address 0: write dropped.
- Read (per port, priority order): ZERO_REG=1 and addr 0 -> 0; else highest-numbered enabled write port to same address -> its wr_data (bypass); else stored value.
- Busy next-state per register r: set_en && set_addr==r -> 1; else any enabled write to r with wr_clear=1 -> 0; else hold. Set beats clear in the same cycle (new producer issued as old one retires).
- wr_en=1 with wr_clear=0 updates data, leaves busy unchanged.
- rd_busy: busy[addr] AND NOT (same-cycle enabled clearing write to addr). Same-cycle set_en is not visible until next cycle. Address 0 with ZERO_REG=1 -> 0.
- Reset: on edge with reset=1 all registers and busy bits <=0; wr_en, set_en ignored that cycle. While reset=1, rd_data=0 and rd_busy=0 on all ports (bypass disabled).
- Reset mid-operation discards pending busy state; no write issued in the reset cycle lands.

## Timing
- Read latency 0 (combinational from rd_addr, wr_*, stored state).
- Write latency 1: value in array after the edge; visible same cycle via bypass.
- Busy set latency 1; busy clear visible same cycle via rd_busy masking, in array after edge.
- No combinational path from rd_addr to any state; no loops.
- Output reset values: rd_data=0, rd_busy=0 throughout reset and on first cycle after (array cleared).

## Test plan
- Reset then read all 32 registers on both ports -> rd_data=0, rd_busy=0; write 0xDEADBEEF to r0 -> r0 still reads 0.
- Port0 writes r5=0x11111111 while rd_addr0=5 -> rd_data0=0x11111111 same cycle; next cycle (no write) still 0x11111111.
- Port0 and port1 both write r7 (0xAAAA0000 / 0x0000BBBB) same cycle -> bypass and stored value 0x0000BBBB.
- set_en r9 -> rd_busy for r9 =0 same cycle, 1 next; write r9 wr_clear=1 -> rd_busy=0 that cycle, stays 0 after; write with wr_clear=0 -> busy stays 1.
- set_en r3 and clearing write r3 same cycle -> r3 busy=1 next cycle, data updated.
- Write r12=0x12345678, set busy r12, assert reset one cycle with wr_en=1 to r12=0xFFFFFFFF -> after reset r12=0, busy=0.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with same-cycle write bypass,
// optional hardwired zero register and a per-register busy scoreboard.
module regfile_mp #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 5,
   parameter int READ_PORTS  = 2,
   parameter int WRITE_PORTS = 2,
   parameter int ZERO_REG    = 1
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [WRITE_PORTS-1:0]            wr_en,
   input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] wr_addr,
   input  logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
   input  logic [WRITE_PORTS-1:0]            wr_clear,
   input  logic [READ_PORTS*ADDR_WIDTH-1:0]  rd_addr,
   output logic [READ_PORTS*DATA_WIDTH-1:0]  rd_data,
   output logic [READ_PORTS-1:0]             rd_busy,
   input  logic                              set_en,
   input  logic [ADDR_WIDTH-1:0]             set_addr
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]      busy_q;
   logic [DEPTH-1:0]      busy_d;
   logic [DEPTH-1:0]      clr_v;   // registers whose busy bit is cleared this cycle

   // Write ports in ascending order so the highest-numbered port wins
   always_comb begin
      regs_d = regs_q;
      clr_v  = '0;
      for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
         if (wr_en[p] &&
             !((ZERO_REG != 0) && (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
            regs_d[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
            clr_v[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]]  = wr_clear[p];
         end
      end
   end

   // Busy next state: a new issue (set) beats a retiring write (clear)
   always_comb begin
      busy_d = busy_q & ~clr_v;
      if (set_en) begin
         busy_d[set_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_d[0] = 1'b0;
      end
   end

   // State register; reset clears data and busy and discards that cycle's writes
   always_ff @(posedge clock) begin
      if (reset) begin
         regs_q <= '{default: '0};
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   // Combinational read ports with bypass from the highest matching write port
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned r = 0; r < READ_PORTS; r++) begin
         if (!reset &&
             !((ZERO_REG != 0) && (rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
            rd_data[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
            rd_busy[r] = busy_q[rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]] &
                         ~clr_v[rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]];
            for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
               if (wr_en[p] &&
                   (wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH])) begin
                  rd_data[r*DATA_WIDTH +: DATA_WIDTH] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors with a scoreboard queue and a decoupled monitor.
module tb_regfile_mp;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic [1:0]  wr_clear;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        set_en;
   logic [4:0]  set_addr;

   typedef struct {
      string       name;
      int          port;
      logic [31:0] data;
      logic        busy;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   regfile_mp #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (5),
      .READ_PORTS (2),
      .WRITE_PORTS(2),
      .ZERO_REG   (1)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_clear(wr_clear),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .rd_busy (rd_busy),
      .set_en  (set_en),
      .set_addr(set_addr)
   );

   always #5 clock = ~clock;

   // Monitor: outputs are presented every cycle; check everything queued for it
   always @(negedge clock) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         logic [31:0] d;
         e = exp_q.pop_front();
         d = rd_data[e.port*32 +: 32];
         n_cmp++;
         if (d !== e.data) begin
            n_mis++;
            $display("FAIL %s port%0d data: got %h expected %h", e.name, e.port, d, e.data);
         end
         n_cmp++;
         if (rd_busy[e.port] !== e.busy) begin
            n_mis++;
            $display("FAIL %s port%0d busy: got %b expected %b", e.name, e.port, rd_busy[e.port], e.busy);
         end
      end
   end

   task automatic expect_rd(input string name, input int port, input logic [31:0] data, input logic busy);
      exp_t e;
      e.name = name; e.port = port; e.data = data; e.busy = busy;
      exp_q.push_back(e);
   endtask

   // Advance to just after the next rising edge and return all controls to idle
   task automatic next_cycle();
      @(posedge clock);
      #1;
      wr_en = '0; wr_addr = '0; wr_data = '0; wr_clear = '0;
      set_en = 1'b0; set_addr = '0; rd_addr = '0; reset = 1'b0;
   endtask

   task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d, input logic clr);
      wr_en[port] = 1'b1;
      wr_addr[port*5 +: 5] = a;
      wr_data[port*32 +: 32] = d;
      wr_clear[port] = clr;
   endtask

   task automatic rd(input int port, input logic [4:0] a);
      rd_addr[port*5 +: 5] = a;
   endtask

   initial begin
      int waited;
      reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; wr_clear = '0;
      set_en = 1'b0; set_addr = '0; rd_addr = '0;
      #1;
      rd(0, 5'd0); rd(1, 5'd1);
      expect_rd("in_reset", 0, 32'h0, 1'b0);
      expect_rd("in_reset", 1, 32'h0, 1'b0);

      // Sweep all registers after reset
      for (int r = 0; r < 32; r++) begin
         next_cycle();
         rd(0, 5'(r)); rd(1, 5'(31 - r));
         expect_rd("post_reset_sweep", 0, 32'h0, 1'b0);
         expect_rd("post_reset_sweep", 1, 32'h0, 1'b0);
      end

      // r0 is hardwired: write and busy-set dropped
      next_cycle();
      wr(0, 5'd0, 32'hDEADBEEF, 1'b0); set_en = 1'b1; set_addr = 5'd0; rd(0, 5'd0);
      expect_rd("r0_write_same", 0, 32'h0, 1'b0);
      next_cycle();
      rd(0, 5'd0);
      expect_rd("r0_write_after", 0, 32'h0, 1'b0);

      // Bypass then stored value
      next_cycle();
      wr(0, 5'd5, 32'h11111111, 1'b0); rd(0, 5'd5);
      expect_rd("r5_bypass", 0, 32'h11111111, 1'b0);
      next_cycle();
      rd(0, 5'd5);
      expect_rd("r5_stored", 0, 32'h11111111, 1'b0);

      // Two ports to the same address: port1 wins
      next_cycle();
      wr(0, 5'd7, 32'hAAAA0000, 1'b0); wr(1, 5'd7, 32'h0000BBBB, 1'b0);
      rd(0, 5'd7); rd(1, 5'd7);
      expect_rd("r7_conflict_bypass", 0, 32'h0000BBBB, 1'b0);
      expect_rd("r7_conflict_bypass", 1, 32'h0000BBBB, 1'b0);
      next_cycle();
      rd(1, 5'd7);
      expect_rd("r7_conflict_stored", 1, 32'h0000BBBB, 1'b0);

      // Busy set / clear sequence on r9
      next_cycle();
      set_en = 1'b1; set_addr = 5'd9; rd(0, 5'd9);
      expect_rd("r9_set_same", 0, 32'h0, 1'b0);
      next_cycle();
      rd(0, 5'd9);
      expect_rd("r9_set_next", 0, 32'h0, 1'b1);
      next_cycle();
      wr(1, 5'd9, 32'h00000099, 1'b1); rd(0, 5'd9);
      expect_rd("r9_clear_same", 0, 32'h00000099, 1'b0);
      next_cycle();
      rd(0, 5'd9);
      expect_rd("r9_clear_after", 0, 32'h00000099, 1'b0);
      next_cycle();
      set_en = 1'b1; set_addr = 5'd9; rd(0, 5'd9);
      expect_rd("r9_reset_busy", 0, 32'h00000099, 1'b0);
      next_cycle();
      wr(0, 5'd9, 32'h00000055, 1'b0); rd(0, 5'd9);
      expect_rd("r9_noclear_same", 0, 32'h00000055, 1'b1);
      next_cycle();
      rd(0, 5'd9);
      expect_rd("r9_noclear_after", 0, 32'h00000055, 1'b1);

      // Set and clear on r3 in one cycle: set wins
      next_cycle();
      set_en = 1'b1; set_addr = 5'd3; wr(0, 5'd3, 32'h00000033, 1'b1); rd(0, 5'd3);
      expect_rd("r3_set_clr_same", 0, 32'h00000033, 1'b0);
      next_cycle();
      rd(0, 5'd3);
      expect_rd("r3_set_clr_next", 0, 32'h00000033, 1'b1);

      // Reset mid-operation discards data, busy and the reset-cycle write
      next_cycle();
      wr(0, 5'd12, 32'h12345678, 1'b0); rd(0, 5'd12);
      expect_rd("r12_write", 0, 32'h12345678, 1'b0);
      next_cycle();
      set_en = 1'b1; set_addr = 5'd12; rd(0, 5'd12);
      expect_rd("r12_set", 0, 32'h12345678, 1'b0);
      next_cycle();
      rd(0, 5'd12);
      expect_rd("r12_busy", 0, 32'h12345678, 1'b1);
      next_cycle();
      reset = 1'b1; wr(0, 5'd12, 32'hFFFFFFFF, 1'b0); set_en = 1'b1; set_addr = 5'd12;
      rd(0, 5'd12); rd(1, 5'd9);
      expect_rd("r12_during_reset", 0, 32'h0, 1'b0);
      expect_rd("r9_during_reset", 1, 32'h0, 1'b0);
      next_cycle();
      rd(0, 5'd12); rd(1, 5'd9);
      expect_rd("r12_after_reset", 0, 32'h0, 1'b0);
      expect_rd("r9_after_reset", 1, 32'h0, 1'b0);
      next_cycle();
      rd(0, 5'd5); rd(1, 5'd3);
      expect_rd("r5_after_reset", 0, 32'h0, 1'b0);
      expect_rd("r3_after_reset", 1, 32'h0, 1'b0);

      // Drain the scoreboard with a bounded wait
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge clock);
         waited++;
      end
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_mis++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
